regfile_nbit: RTL
=================

Name: regfile_nbit

Overview:
Parametrised multi-entry register file, successor to the single N-bit load/reset register. Storage is DEPTH words of N bits, with 1 synchronous write port and 2 combinational read ports. An optional hardwired zero register is supported. A sequencer clears the whole file on request, one entry per cycle. It sits between decode and ALU in the datapath.

Parameters:
N, 64, data width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
ZERO_REG, 31, index of the hardwired-zero entry; a value >= DEPTH disables the zero entry

Ports:
clock  in  1  positive-edge clock
R_n  in  1  asynchronous active-low reset
WE  in  1  write enable
WA  in  ADDR_W  write address
WD  in  N  write data
RA1  in  ADDR_W  read address, port 1
RA2  in  ADDR_W  read address, port 2
RD1  out  N  read data, port 1 (combinational)
RD2  out  N  read data, port 2 (combinational)
CLR  in  1  start a sweep-clear (level sampled on the clock edge)
BUSY  out  1  sweep-clear in progress

Behaviour:
- Reset (R_n=0, asynchronous): all entries = 0; FSM = IDLE; sweep pointer = 0; BUSY = 0. RD1/RD2 therefore read 0.
- Write: on the posedge, when WE=1, FSM=IDLE and WA!=ZERO_REG, set mem[WA] <= WD. Write latency is 1 cycle. Otherwise mem holds its value.
- Read, base value: RDx = mem[RAx], combinational, no latency.
- Read, zero entry: RAx==ZERO_REG always gives RDx = 0, regardless of bypass.
- Both read ports may address the same entry, or the write entry, in the same cycle.
- FSM IDLE: CLR=1 at a posedge moves to CLEAR with ptr=0. A WE in that same cycle is still performed, because the write is evaluated in IDLE.
- FSM CLEAR: BUSY=1.
  - Each posedge: mem[ptr] <= 0, then ptr <= ptr+1.
  - When ptr==DEPTH-1 (the final clear), next state is IDLE and ptr wraps to 0.
  - The sweep takes exactly DEPTH cycles; BUSY deasserts on the cycle after the last entry is cleared.
- During CLEAR:
  - WE is ignored; the write is dropped, not queued.
  - CLR is ignored; the sweep does not restart.
  - Reads return the current contents: already-cleared entries read 0, uncleared entries read their old values.
- BUSY is registered and equals (state==CLEAR).
- Reset mid-sweep: everything returns to 0 immediately; FSM = IDLE; BUSY = 0.
- Writes and reads are unsigned bit copies; no arithmetic except the ptr increment (ADDR_W bits, wraps).

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: write-through bypass. If WE=1, FSM=IDLE, WA==RAx and WA!=ZERO_REG, then RDx = WD in the same cycle, before the edge.
- Undefined: RDx shows the old mem[RAx] until the cycle after the write edge.
- In both cases the ZERO_REG rule takes precedence, and no bypass occurs during CLEAR.

Test Plan:
1. Reset, then write 0xDEADBEEF_CAFEF00D to entry 5. Next cycle RA1=5 -> RD1=0xDEADBEEF_CAFEF00D; RA2=6 -> RD2=0.
2. WE=1, WA=31, WD=all ones; then RA1=31 -> RD1=0 (zero register). Also WA=3, WD=0x1234 with RA2=3 in the same cycle -> RD2=0x1234 if REGFILE_BYPASS_EN is defined, else the old value (0), becoming 0x1234 next cycle.
3. Fill entries 0..30 with value i+1, then pulse CLR for 1 cycle:
   - BUSY is high for exactly 32 cycles.
   - After 10 sweep cycles, RA1=9 -> 0 and RA2=20 -> 21.
   - After BUSY falls, every entry reads 0.
4. During CLEAR: WE=1, WA=2, WD=0x55, then a second CLR pulse. After the sweep, entry 2 = 0 and the total BUSY length is still 32 cycles.
5. Assert R_n=0 asynchronously (between clock edges) at sweep cycle 7 with entries nonzero. BUSY and all reads go to 0 immediately. After release, a WE to entry 4 works on the first edge.
6. Same cycle: CLR=1 and WE=1, WA=8, WD=0x77 while IDLE. Entry 8 is written, then cleared at sweep cycle 9, reading 0x77 before that point and 0 after.

Source files
------------

// File: rtl/regfile_nbit.sv
// Multi-entry register file: 1 write port, 2 async read ports, sweep-clear.
// Optional write-through bypass when REGFILE_BYPASS_EN is defined.
module regfile_nbit #(
  parameter int N        = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31
) (
  input  logic              clock,
  input  logic              R_n,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WA,
  input  logic [N-1:0]      WD,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  output logic [N-1:0]      RD1,
  output logic [N-1:0]      RD2,
  input  logic              CLR,
  output logic              BUSY
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam bit ZEN = (ZERO_REG < DEPTH);
  localparam logic [ADDR_W-1:0] ZIDX = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W-1:0] LAST = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_nx;
  logic              busy_q;
  logic [N-1:0]      mem [DEPTH];

  logic wa_zero;
  logic ra1_zero;
  logic ra2_zero;
  logic wr_en;

  assign wa_zero  = ZEN && (WA == ZIDX);
  assign ra1_zero = ZEN && (RA1 == ZIDX);
  assign ra2_zero = ZEN && (RA2 == ZIDX);

  // Writes only land while idle; the zero entry is never written.
  assign wr_en = WE && (state == IDLE) && !wa_zero;

  assign BUSY = busy_q;

  // State, sweep pointer and registered busy flag.
  always_ff @(posedge clock or negedge R_n) begin
    if (!R_n) begin
      state  <= IDLE;
      ptr    <= '0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nx;
      ptr    <= ptr_nx;
      busy_q <= (state_nx == CLEAR);
    end
  end

  // Next state: CLR starts a sweep, last entry returns to idle.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    unique case (state)
      IDLE: begin
        if (CLR) begin
          state_nx = CLEAR;
          ptr_nx   = '0;
        end
      end
      CLEAR: begin
        ptr_nx = ptr + 1'b1;
        if (ptr == LAST) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
        ptr_nx   = '0;
      end
    endcase
  end

  // Storage: port write while idle, one entry zeroed per sweep cycle.
  always_ff @(posedge clock or negedge R_n) begin
    if (!R_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[WA] <= WD;
    end else if (state == CLEAR) begin
      mem[ptr] <= '0;
    end
  end

  // Read ports: array lookup, optional bypass, zero entry wins.
  always_comb begin
    RD1 = mem[RA1];
    RD2 = mem[RA2];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (WA == RA1)) begin
      RD1 = WD;
    end
    if (wr_en && (WA == RA2)) begin
      RD2 = WD;
    end
`endif
    if (ra1_zero) begin
      RD1 = '0;
    end
    if (ra2_zero) begin
      RD2 = '0;
    end
  end

endmodule
